// File: rtl/uart_rx_gen.sv
// Parametrised UART receiver: DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// Optional feature macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module uart_rx_gen #(
  parameter int BAUD_END    = 5208,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 po_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int             MID     = BAUD_END / 2 - 1;
  localparam int             CW      = $clog2(BAUD_END);
  localparam logic [CW-1:0]  C_MID   = CW'(MID);
  localparam logic [CW-1:0]  C_END   = CW'(BAUD_END - 1);
  localparam logic [3:0]     C_DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     C_SLAST = 4'(STOP_BITS - 1);
  localparam logic           HAS_PAR = (PARITY_MODE != 0);
  localparam logic           ODD_PAR = (PARITY_MODE == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_rx_s1, r_rx_s, r_rx_d;
  logic [CW-1:0]        r_baud_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_acc, r_frm_acc;
  logic                 w_start, w_sample, w_bit, w_done;

  // Odd parity wants an odd total count of ones over data plus parity bit.
  function automatic logic f_par_err(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != ODD_PAR;
  endfunction

  assign w_start = r_rx_d & ~r_rx_s;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] C_MIDM1 = CW'(MID - 1);
  localparam logic [CW-1:0] C_MIDP1 = CW'(MID + 1);
  logic r_maj0, r_maj1;

  // Capture the two earlier votes; the third is the live rx_s at MID+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_maj0 <= 1'b1;
      r_maj1 <= 1'b1;
    end else begin
      if (r_baud_cnt == C_MIDM1) r_maj0 <= r_rx_s;
      if (r_baud_cnt == C_MID)   r_maj1 <= r_rx_s;
    end
  end

  assign w_sample = (r_baud_cnt == C_MIDP1);
  assign w_bit    = (r_maj0 & r_maj1) | (r_maj0 & r_rx_s) | (r_maj1 & r_rx_s);
`else
  assign w_sample = (r_baud_cnt == C_MID);
  assign w_bit    = r_rx_s;
`endif

  // Two-stage synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= rs232_rx;
      r_rx_s  <= r_rx_s1;
      r_rx_d  <= r_rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state and frame-complete strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_START;
        else         w_state_nxt = S_IDLE;
      end
      S_START: begin
        if (w_sample) begin
          if (w_bit) w_state_nxt = S_IDLE;
          else       w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_sample && (r_bit_cnt == C_DLAST)) w_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
        else                                    w_state_nxt = S_DATA;
      end
      S_PARITY: begin
        if (w_sample) w_state_nxt = S_STOP;
        else          w_state_nxt = S_PARITY;
      end
      S_STOP: begin
        if (w_sample && (r_bit_cnt == C_SLAST)) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Baud counter: held at zero outside a frame, wraps once per bit.
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE) || (w_state_nxt == S_IDLE)) r_baud_cnt <= {CW{1'b0}};
    else if (r_baud_cnt == C_END)                               r_baud_cnt <= {CW{1'b0}};
    else                                                        r_baud_cnt <= r_baud_cnt + CW'(1);
  end

  // Bit counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst || (w_state_nxt != r_state))                          r_bit_cnt <= 4'd0;
    else if (w_sample && ((r_state == S_DATA) || (r_state == S_STOP))) r_bit_cnt <= r_bit_cnt + 4'd1;
    else                                                          r_bit_cnt <= r_bit_cnt;
  end

  // Shift register and per-frame error accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= {DATA_BITS{1'b0}};
      r_par_acc <= 1'b0;
      r_frm_acc <= 1'b0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_par_acc <= 1'b0;
      r_frm_acc <= 1'b0;
    end else if (w_sample) begin
      case (r_state)
        S_DATA:   r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
        S_PARITY: r_par_acc <= f_par_err(r_shift, w_bit);
        S_STOP:   r_frm_acc <= r_frm_acc | ~w_bit;
        default:  r_shift   <= r_shift;
      endcase
    end
  end

  // Registered outputs; word and error flags change only with po_flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= {DATA_BITS{1'b0}};
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      po_flag    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      po_flag <= w_done;
      busy    <= (w_state_nxt != S_IDLE);
      if (w_done) begin
        rx_data    <= r_shift;
        parity_err <= r_par_acc;
        frame_err  <= r_frm_acc | ~w_bit;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_gen.sv
// Directed bench for uart_rx_gen: 8N1, 8E1 and 7N2 instances driven with hand-built frames.
module tb_uart_rx_gen;
  localparam int BAUD = 56;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 536;
`else
  localparam int LAT = 535;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx0, rx1, rx2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       pf0, pf1, pf2, pe0, pe1, pe2, fe0, fe1, fe2, bz0, bz1, bz2;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, f0 = 0, f1 = 0, f2 = 0;
  int t_start0 = 0, t_flag0 = 0;

  uart_rx_gen #(.BAUD_END(BAUD), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .rs232_rx(rx0), .rx_data(d0), .po_flag(pf0),
    .parity_err(pe0), .frame_err(fe0), .busy(bz0));
  uart_rx_gen #(.BAUD_END(BAUD), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .rs232_rx(rx1), .rx_data(d1), .po_flag(pf1),
    .parity_err(pe1), .frame_err(fe1), .busy(bz1));
  uart_rx_gen #(.BAUD_END(BAUD), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .rs232_rx(rx2), .rx_data(d2), .po_flag(pf2),
    .parity_err(pe2), .frame_err(fe2), .busy(bz2));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pf0) begin
      f0      <= f0 + 1;
      t_flag0 <= cyc;
    end
    if (pf1) f1 <= f1 + 1;
    if (pf2) f2 <= f2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // One bit period; optional 1-cycle inverted glitch near the bit centre.
  task automatic send_bit(input int sel, input logic v, input logic glitch);
    drive(sel, v);
    if (glitch) begin
      tick(28);
      drive(sel, ~v);
      tick(1);
      drive(sel, v);
      tick(BAUD - 29);
    end else begin
      tick(BAUD);
    end
  endtask

  // par < 0 means no parity bit; gbit selects a data bit to glitch (-1 none).
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits, input int par,
                            input logic stop1, input int nstop, input logic stop2, input int gbit);
    if (sel == 0) t_start0 = cyc;
    send_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(sel, data[i], (i == gbit));
    if (par >= 0) send_bit(sel, par[0], 1'b0);
    send_bit(sel, stop1, 1'b0);
    if (nstop == 2) send_bit(sel, stop2, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(5);

    // Reset state
    check("rst_data0", 32'(d0), 32'h0);
    check("rst_flags0", 32'({pf0, pe0, fe0, bz0}), 32'h0);
    check("rst_busy12", 32'({bz1, bz2, pf1, pf2}), 32'h0);

    // Back-to-back 8N1 frames
    send_frame(0, 9'h055, 8, -1, 1'b1, 1, 1'b1, -1);
    check("b2b_cnt1", 32'(f0), 32'd1);
    check("b2b_data1", 32'(d0), 32'h55);
    check("latency", 32'(t_flag0 - t_start0), 32'(LAT));
    check("b2b_errs1", 32'({pe0, fe0}), 32'h0);
    send_frame(0, 9'h0A3, 8, -1, 1'b1, 1, 1'b1, -1);
    tick(10);
    check("b2b_cnt2", 32'(f0), 32'd2);
    check("b2b_data2", 32'(d0), 32'hA3);

    // Even parity: 0xA3 has four ones
    send_frame(1, 9'h0A3, 8, 0, 1'b1, 1, 1'b1, -1);
    tick(BAUD);
    check("par_ok_cnt", 32'(f1), 32'd1);
    check("par_ok_err", 32'({pe1, fe1}), 32'h0);
    check("par_ok_data", 32'(d1), 32'hA3);
    send_frame(1, 9'h0A3, 8, 1, 1'b1, 1, 1'b1, -1);
    tick(BAUD);
    check("par_bad_cnt", 32'(f1), 32'd2);
    check("par_bad_err", 32'(pe1), 32'h1);
    check("par_bad_data", 32'(d1), 32'hA3);

    // False start: 200 ns low pulse
    drive(0, 1'b0);
    tick(10);
    check("glitch_busy_hi", 32'(bz0), 32'h1);
    tick(10);
    drive(0, 1'b1);
    tick(20);
    check("glitch_busy_lo", 32'(bz0), 32'h0);
    tick(BAUD);
    check("glitch_noflag", 32'(f0), 32'd2);
    send_frame(0, 9'h03C, 8, -1, 1'b1, 1, 1'b1, -1);
    tick(10);
    check("after_glitch_cnt", 32'(f0), 32'd3);
    check("after_glitch_data", 32'(d0), 32'h3C);

    // Framing error followed by a held-low break
    send_frame(0, 9'h0FF, 8, -1, 1'b0, 1, 1'b1, -1);
    tick(5 * BAUD);
    check("brk_cnt", 32'(f0), 32'd4);
    check("brk_ferr", 32'(fe0), 32'h1);
    check("brk_data", 32'(d0), 32'hFF);
    check("brk_busy", 32'(bz0), 32'h0);
    drive(0, 1'b1);
    tick(2 * BAUD);
    check("brk_noflag", 32'(f0), 32'd4);
    send_frame(0, 9'h03C, 8, -1, 1'b1, 1, 1'b1, -1);
    tick(10);
    check("brk_recover_cnt", 32'(f0), 32'd5);
    check("brk_recover_ferr", 32'(fe0), 32'h0);

    // 7 data bits, 2 stop bits, second stop low
    send_frame(2, 9'h041, 7, -1, 1'b1, 2, 1'b0, -1);
    drive(2, 1'b1);
    tick(BAUD);
    check("s2_cnt", 32'(f2), 32'd1);
    check("s2_data", 32'(d2), 32'h41);
    check("s2_errs", 32'({fe2, pe2}), 32'h2);
    send_frame(2, 9'h02A, 7, -1, 1'b1, 2, 1'b1, -1);
    tick(BAUD);
    check("s2_clean_cnt", 32'(f2), 32'd2);
    check("s2_clean", 32'({d2, fe2}), 32'({7'h2A, 1'b0}));

    // Reset in the middle of the data bits of 0x12
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b0, 1'b0);
    drive(0, 1'b1);
    tick(28);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("mid_rst_out0", 32'({d0, fe0, bz0}), 32'h0);
    check("mid_rst_out2", 32'({d2, fe2}), 32'h0);
    tick(2 * BAUD);
    check("mid_rst_noflag", 32'(f0), 32'd5);
    send_frame(0, 9'h034, 8, -1, 1'b1, 1, 1'b1, -1);
    tick(10);
    check("post_rst_cnt", 32'(f0), 32'd6);
    check("post_rst_data", 32'({d0, fe0, pe0}), 32'({8'h34, 2'b00}));

`ifdef UART_RX_MAJORITY_EN
    // Single-cycle low glitch at a data-bit centre must be voted out
    send_frame(0, 9'h0FF, 8, -1, 1'b1, 1, 1'b1, 3);
    tick(10);
    check("maj_cnt", 32'(f0), 32'd7);
    check("maj_data", 32'(d0), 32'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
